pipeline_debug_sequencer: RTL and testbench
===========================================

Name: pipeline_debug_sequencer

Overview:
- Host-facing run-control and state-dump controller for the 5-stage MIPS pipeline.
- Accepts single-byte commands from a host link (UART RX side) and gates the pipeline clock enable for free-run, single-step and halt.
- Counts executed cycles and stops automatically when a HALT instruction reaches WB.
- On request, serialises the cycle count, all 32 registers and a window of data memory as a byte stream to the host link (UART TX side). While dumping, it drives the data memory debug address and debugMode.

Parameters:
- MEM_DUMP_WORDS, 16, number of 32-bit data memory words dumped, starting at address 0.
- CYCLE_W, 32, width of the cycle counter. Legal range is 1..32; the counter is zero-extended to 32 bits when dumped.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command byte valid.
- cmd_ready  out  1  sequencer accepts command this cycle.
- cmd_code  in  8  command: 0x63 'c' run, 0x73 's' step, 0x68 'h' halt, 0x64 'd' dump; any other value is ignored.
- halt_wb  in  1  HALT instruction is in WB this cycle.
- pipe_en  out  1  pipeline clock enable.
- reg_sel  out  5  register file debug read index.
- reg_data  in  32  combinational read of reg_sel.
- DebugAddress  out  32  data memory debug word address.
- debugMode  out  1  data memory in debug-read mode.
- mem_data  in  32  data memory read data, valid 1 cycle after DebugAddress.
- tx_valid  out  1  byte to host valid.
- tx_ready  in  1  host link accepts byte.
- tx_data  out  8  byte to host.
- cycle_count  out  CYCLE_W  cycles with pipe_en=1 since reset.
- halted  out  1  a HALT was retired.

Behaviour:
- Reset values: pipe_en=0, cmd_ready=1, reg_sel=0, DebugAddress=0, debugMode=0, tx_valid=0, tx_data=0, cycle_count=0, halted=0. State after reset is IDLE.
- States: IDLE, RUN, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT_MEM.
- A command is accepted when cmd_valid && cmd_ready.
- cmd_ready=1 only in IDLE and RUN. In RUN, only 'h' and 'd' have an effect; other codes are dropped.
- IDLE:
  - 'c' → RUN, if halted=0.
  - 's' → STEP, if halted=0.
  - 'd' → DUMP_LOAD.
  - 'c' or 's' while halted=1 is ignored. Only reset clears halted.
- RUN:
  - pipe_en=1 every cycle.
  - 'h' → IDLE; pipe_en=0 from the next cycle.
  - 'd' → DUMP_LOAD; the pipeline stops first.
- STEP:
  - pipe_en=1 for exactly one cycle, then → IDLE.
- cycle_count increments on each cycle with pipe_en=1 and wraps modulo 2^CYCLE_W.
- halt_wb=1 while pipe_en=1:
  - halted<=1 and pipe_en=0 from the next cycle.
  - State → IDLE, unless a 'd' is accepted in the same cycle, in which case → DUMP_LOAD.
- halt_wb while pipe_en=0 is ignored.
- Dump sequence:
  - Word index w runs from 0 to 32+MEM_DUMP_WORDS.
  - w=0 is the cycle count.
  - w=1..32 are registers 0..31 (reg_sel=w-1).
  - The remaining words are memory words 0..MEM_DUMP_WORDS-1.
  - Each word is sent as 4 bytes, MSB first.
- DUMP_LOAD:
  - Register or cycle words: latch the word into a shift register, then → DUMP_SEND.
  - Memory words: drive DebugAddress=(w-33)*4 and debugMode=1, then → DUMP_WAIT_MEM.
- DUMP_WAIT_MEM: latch mem_data after one cycle, then → DUMP_SEND.
- DUMP_SEND:
  - tx_valid=1 with tx_data = the current byte.
  - The byte advances only on tx_valid && tx_ready.
  - tx_data stays stable while tx_ready=0.
  - After byte 3 of the last word → IDLE, with debugMode=0 and tx_valid=0 on the next cycle.
- pipe_en=0 throughout all DUMP_* states, and cycle_count is frozen.
- Reset asserted mid-dump or mid-run: all state is cleared immediately, and no partial byte is held.
- Total dump length is 4*(33+MEM_DUMP_WORDS) bytes, which is 196 with the defaults.

Optional Feature:
- Macro: DBG_PC_DUMP_EN.
- When defined:
  - Adds input pc_if [31:0].
  - Word w=0 becomes pc_if, sampled at dump start. All subsequent words shift up by one.
  - Dump length becomes 4*(34+MEM_DUMP_WORDS).
- When undefined: the port is absent and the dump is exactly as described in Behaviour.

Test Plan:
- Reset, then 's' three times with idle gaps → pipe_en high for exactly 3 single cycles; cycle_count=3; state IDLE.
- 'c', 10 cycles, then 'h' → cycle_count=11 (10 cycles plus the acceptance cycle of 'h'); pipe_en=0 afterwards; a following 's' gives cycle_count=12.
- RUN with halt_wb pulsed at cycle_count=7 → halted=1, pipe_en=0 next cycle; subsequent 'c' and 's' are ignored; cycle_count stays at 8.
- 'd' with reg r5=0xDEADBEEF, mem word 2=0x12345678, cycle_count=8, tx_ready=1 → 196 bytes:
  - bytes 0..3 = 00 00 00 08;
  - bytes 24..27 = DE AD BE EF;
  - bytes 140..143 = 12 34 56 78.
- Same dump with tx_ready toggled 1-of-3 cycles → identical byte stream; tx_data stable while stalled; debugMode=1 only during the memory phase.
- Assert rst_n low at byte 50 of a dump → tx_valid=0, debugMode=0, cycle_count=0 immediately; 'd' after release restarts from byte 0.

Source files
------------

// File: rtl/pipeline_debug_sequencer.sv
// Run-control and state-dump sequencer for the 5-stage MIPS pipeline host debug link.
// Optional DBG_PC_DUMP_EN adds pc_if and prepends it as the first dumped word.
//
// state           | meaning
// S_IDLE          | pipeline stopped, waiting for a host command
// S_RUN           | pipeline free-running until 'h', 'd' or a retired HALT
// S_STEP          | pipeline enabled for exactly one cycle
// S_DUMP_LOAD     | select the next dump word (latch it, or address data memory)
// S_DUMP_WAIT_MEM | data memory read in flight, latch mem_data
// S_DUMP_SEND     | shift the latched word out MSB first, one byte per handshake
module pipeline_debug_sequencer #(
    parameter int MEM_DUMP_WORDS = 16,
    parameter int CYCLE_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_code,
    input  logic               halt_wb,
    output logic               pipe_en,
    output logic [4:0]         reg_sel,
    input  logic [31:0]        reg_data,
    output logic [31:0]        DebugAddress,
    output logic               debugMode,
    input  logic [31:0]        mem_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               halted
`ifdef DBG_PC_DUMP_EN
    ,
    input  logic [31:0]        pc_if
`endif
);

`ifdef DBG_PC_DUMP_EN
    localparam int CYC_W0 = 1;
`else
    localparam int CYC_W0 = 0;
`endif
    localparam int REG_W0 = CYC_W0 + 1;
    localparam int MEM_W0 = CYC_W0 + 33;
    localparam int LAST_W = MEM_W0 + MEM_DUMP_WORDS - 1;
    localparam int WI_W   = $clog2(LAST_W + 1);

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DUMP_LOAD,
        S_DUMP_SEND,
        S_DUMP_WAIT_MEM
    } state_t;

    state_t            state, state_nx;
    logic [WI_W-1:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       shift_q;
    logic [31:0]       widx;
    logic [31:0]       cyc_ext;
    logic [31:0]       load_word;
    logic              cmd_acc, halt_hit, dumping, in_mem, in_reg, last_word;

    assign widx      = 32'(word_idx);
    assign in_mem    = widx >= 32'(MEM_W0);
    assign in_reg    = (widx >= 32'(REG_W0)) && !in_mem;
    assign last_word = widx == 32'(LAST_W);
    assign dumping   = (state == S_DUMP_LOAD) || (state == S_DUMP_SEND) ||
                       (state == S_DUMP_WAIT_MEM);

    assign reg_sel      = in_reg ? 5'(widx - 32'(REG_W0)) : 5'd0;
    assign debugMode    = dumping && in_mem;
    assign DebugAddress = debugMode ? ((widx - 32'(MEM_W0)) << 2) : 32'd0;
    assign tx_valid     = (state == S_DUMP_SEND);
    assign tx_data      = tx_valid ? shift_q[31:24] : 8'd0;

    always_comb begin
        cyc_ext                = '0;
        cyc_ext[CYCLE_W-1:0]   = cycle_count;
        load_word              = reg_data;
`ifdef DBG_PC_DUMP_EN
        if (widx == 32'd0) load_word = pc_if;
`endif
        if (widx == 32'(CYC_W0)) load_word = cyc_ext;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = (state == S_IDLE) || (state == S_RUN);
        pipe_en   = (state == S_RUN) || (state == S_STEP);
        cmd_acc   = cmd_valid && cmd_ready;
        halt_hit  = pipe_en && halt_wb;
        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (cmd_code == CMD_RUN && !halted)       state_nx = S_RUN;
                    else if (cmd_code == CMD_STEP && !halted) state_nx = S_STEP;
                    else if (cmd_code == CMD_DUMP)            state_nx = S_DUMP_LOAD;
                end
            end
            S_RUN: begin
                // A dump request wins over a same-cycle HALT retirement.
                if (cmd_acc && cmd_code == CMD_DUMP)
                    state_nx = S_DUMP_LOAD;
                else if (halt_hit || (cmd_acc && cmd_code == CMD_HALT))
                    state_nx = S_IDLE;
            end
            S_STEP:          state_nx = S_IDLE;
            S_DUMP_LOAD:     state_nx = in_mem ? S_DUMP_WAIT_MEM : S_DUMP_SEND;
            S_DUMP_WAIT_MEM: state_nx = S_DUMP_SEND;
            S_DUMP_SEND: begin
                if (tx_ready && byte_idx == 2'd3)
                    state_nx = last_word ? S_IDLE : S_DUMP_LOAD;
            end
            default:         state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            halted      <= 1'b0;
            word_idx    <= '0;
            byte_idx    <= '0;
            shift_q     <= '0;
        end else begin
            if (pipe_en)  cycle_count <= cycle_count + CYCLE_W'(1);
            if (halt_hit) halted <= 1'b1;
            case (state)
                S_DUMP_LOAD: begin
                    if (!in_mem) shift_q <= load_word;
                end
                S_DUMP_WAIT_MEM: shift_q <= mem_data;
                S_DUMP_SEND: begin
                    if (tx_ready) begin
                        shift_q  <= shift_q << 8;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            word_idx <= last_word ? '0 : word_idx + WI_W'(1);
                    end
                end
                default: begin
                    word_idx <= '0;
                    byte_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Directed bench for pipeline_debug_sequencer: run-control checks plus a byte
// scoreboard for the dump stream, checked by an independent monitor.
module tb_pipeline_debug_sequencer;

`ifdef DBG_PC_DUMP_EN
    localparam int OFS = 4;
`else
    localparam int OFS = 0;
`endif
    localparam int DUMP_BYTES = 196 + OFS;
    localparam int MEM_BYTE0  = 132 + OFS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_code = 8'h00;
    logic        halt_wb = 1'b0;
    logic        pipe_en;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [31:0] DebugAddress;
    logic        debugMode;
    logic [31:0] mem_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic [31:0] cycle_count;
    logic        halted;
`ifdef DBG_PC_DUMP_EN
    logic [31:0] pc_if = 32'h0040_0100;
`endif

    pipeline_debug_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .halt_wb(halt_wb), .pipe_en(pipe_en),
        .reg_sel(reg_sel), .reg_data(reg_data),
        .DebugAddress(DebugAddress), .debugMode(debugMode), .mem_data(mem_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .cycle_count(cycle_count), .halted(halted)
`ifdef DBG_PC_DUMP_EN
        , .pc_if(pc_if)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] regs [32];
    logic [31:0] mem  [16];
    assign reg_data = regs[reg_sel];
    always @(posedge clk) mem_data <= mem[DebugAddress[5:2]];

    int total = 0;
    int bad = 0;
    logic [7:0] sb_q[$];
    logic [7:0] cap [256];
    int ncap = 0;
    int pe_cnt = 0;
    int pe_b2b = 0;
    logic pe_prev = 1'b0;
    logic stall_mode = 1'b0;
    int rdy_ph = 0;
    logic stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // tx_ready pattern: always high, or high one cycle in three
    always @(posedge clk) begin
        #1;
        rdy_ph   = (rdy_ph + 1) % 3;
        tx_ready = !stall_mode || (rdy_ph == 0);
    end

    always @(negedge clk) begin
        if (pipe_en) pe_cnt++;
        if (pipe_en && pe_prev) pe_b2b++;
        pe_prev = pipe_en;
    end

    // Monitor: pops the scoreboard on every accepted byte
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid)
                check("debug_mode_phase", 32'(debugMode), 32'(ncap >= MEM_BYTE0));
            if (cmd_ready)
                check("debug_mode_idle", 32'(debugMode), 32'd0);
            if (tx_valid && tx_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(exp_b));
                end
                if (ncap < 256) cap[ncap] = tx_data;
                ncap++;
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic send_cmd(input logic [7:0] code);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_code  = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) sb_q.push_back(w[31 - 8*b -: 8]);
    endtask

    task automatic push_dump(input logic [31:0] cyc);
`ifdef DBG_PC_DUMP_EN
        push_word(pc_if);
`endif
        push_word(cyc);
        for (int i = 0; i < 32; i++) push_word(regs[i]);
        for (int i = 0; i < 16; i++) push_word(mem[i]);
    endtask

    task automatic wait_dump(input string name);
        int k;
        k = 0;
        while (!(ncap == DUMP_BYTES && cmd_ready && !tx_valid) && k < 5000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({name, "_len"}, 32'(ncap), 32'(DUMP_BYTES));
        check({name, "_idle"}, 32'(cmd_ready), 32'd1);
        check({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_txv_off"}, 32'(tx_valid), 32'd0);
        check({name, "_dbg_off"}, 32'(debugMode), 32'd0);
    endtask

    task automatic check_key_bytes(input string name, input logic [31:0] cyc);
        check({name, "_cycle"}, {cap[OFS], cap[OFS+1], cap[OFS+2], cap[OFS+3]}, cyc);
        check({name, "_r5"}, {cap[OFS+24], cap[OFS+25], cap[OFS+26], cap[OFS+27]}, 32'hDEADBEEF);
        check({name, "_mem2"}, {cap[OFS+140], cap[OFS+141], cap[OFS+142], cap[OFS+143]}, 32'h12345678);
    endtask

    initial begin
        int k;
        int pe0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        regs[0] = 32'h0;
        regs[5] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) mem[i] = 32'h8000_0000 + 32'(i) * 32'h11;
        mem[2] = 32'h12345678;

        // reset values
        #2;
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("rst_dbg", {26'd0, debugMode, reg_sel}, 32'd0);
        check("rst_dbg_addr", DebugAddress, 32'd0);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        do_reset();

        // three single steps
        pe_cnt = 0;
        pe_b2b = 0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(8'h73);
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        check("step_pulses", 32'(pe_cnt), 32'd3);
        check("step_b2b", 32'(pe_b2b), 32'd0);
        check("step_cycle", cycle_count, 32'd3);
        check("step_idle", {31'd0, cmd_ready}, 32'd1);
        send_cmd(8'h41);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bad_code_cycle", cycle_count, 32'd3);

        // run 10 cycles then halt
        do_reset();
        send_cmd(8'h63);
        repeat (9) @(posedge clk);
        send_cmd(8'h68);
        repeat (2) @(negedge clk);
        check("run_cycle", cycle_count, 32'd11);
        check("run_stopped", 32'(pipe_en), 32'd0);
        send_cmd(8'h73);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("run_step_cycle", cycle_count, 32'd12);

        // HALT retired at cycle_count 7
        do_reset();
        send_cmd(8'h63);
        k = 0;
        @(negedge clk);
        while (cycle_count != 32'd7 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("halt_reach7", cycle_count, 32'd7);
        halt_wb = 1'b1;
        @(posedge clk);
        #1;
        halt_wb = 1'b0;
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pipe_off", 32'(pipe_en), 32'd0);
        pe0 = pe_cnt;
        send_cmd(8'h63);
        send_cmd(8'h73);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("halt_cycle", cycle_count, 32'd8);
        check("halt_no_pe", 32'(pe_cnt - pe0), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);

        // dump with tx_ready high
        ncap = 0;
        push_dump(32'd8);
        send_cmd(8'h64);
        wait_dump("dump1");
        check_key_bytes("dump1", 32'd8);

        // dump with tx_ready 1-of-3
        stall_mode = 1'b1;
        ncap = 0;
        push_dump(32'd8);
        send_cmd(8'h64);
        wait_dump("dump2");
        stall_mode = 1'b0;
        check_key_bytes("dump2", 32'd8);
        check("dump2_cycle_frozen", cycle_count, 32'd8);

        // reset in the middle of a dump
        ncap = 0;
        push_dump(32'd8);
        send_cmd(8'h64);
        k = 0;
        while (ncap < 50 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_reach50", 32'(ncap), 32'd50);
        rst_n = 1'b0;
        #1;
        check("mid_txv", 32'(tx_valid), 32'd0);
        check("mid_dbg", 32'(debugMode), 32'd0);
        check("mid_cycle", cycle_count, 32'd0);
        check("mid_halted", 32'(halted), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ncap = 0;
        push_dump(32'd0);
        send_cmd(8'h64);
        wait_dump("dump3");
        check_key_bytes("dump3", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
